// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
// The master side is the upstream pipeline/hazard logic; the slave side is the stage.
interface execute_stage_if #(
  parameter int DATA_W = 19,
  parameter int PC_W   = 15,
  parameter int REG_AW = 5
);
  logic              RegWriteE;
  logic              MemWriteE;
  logic              JumpE;
  logic [1:0]        BranchE;
  logic              ALUSrcE;
  logic              ResultSrcE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [DATA_W-1:0] ImmExtE;
  logic [PC_W-1:0]   PCE;
  logic [REG_AW-1:0] RDE;
  logic              Cant_ByteE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [DATA_W-1:0] ResultW;

  logic              BusyE;
  logic              PCSrcE;
  logic [PC_W-1:0]   PCTargetE;
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic              Cant_ByteM;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [REG_AW-1:0] RdM;

  modport master (
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, RDE, Cant_ByteE, ForwardAE, ForwardBE, ResultW,
    input  BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM,
           ALUResultM, WriteDataM, RdM
  );

  modport slave (
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, RDE, Cant_ByteE, ForwardAE, ForwardBE, ResultW,
    output BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM,
           ALUResultM, WriteDataM, RdM
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the 19-bit 5-stage pipeline: forwarding muxes, ALU, branch
// resolution, iterative shift-add multiplier and the EX/MEM pipeline register.
module execute_stage #(
  parameter int DATA_W   = 19,
  parameter int PC_W     = 15,
  parameter int REG_AW   = 5,
  parameter int MUL_BITS = 19
) (
  input logic            clk,
  input logic            reset,
  execute_stage_if.slave ex
);
  localparam int                CNT_W    = $clog2(MUL_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_BITS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Shifts by DATA_W or more clear the operand instead of wrapping.
  function automatic logic [DATA_W-1:0] f_shl(input logic [DATA_W-1:0] a, input logic [4:0] sh);
    if (int'(sh) >= DATA_W) return '0;
    return a << sh;
  endfunction

  function automatic logic [DATA_W-1:0] f_shr(input logic [DATA_W-1:0] a, input logic [4:0] sh);
    if (int'(sh) >= DATA_W) return '0;
    return a >> sh;
  endfunction

  logic [0:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_mcand;
  logic [DATA_W-1:0]       r_mplier;
  logic [DATA_W-1:0]       r_prod;
  logic                    r_rw;
  logic                    r_mw;
  logic                    r_rs;
  logic                    r_cb;
  logic [REG_AW-1:0]       r_rd;
  logic [DATA_W-1:0]       r_wd;

  logic [DATA_W-1:0]       w_srca;
  logic [DATA_W-1:0]       w_fwdb;
  logic [DATA_W-1:0]       w_srcb;
  logic [DATA_W-1:0]       w_alu;
  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic                    w_cond;
  logic                    w_is_mul;
  logic                    w_mul_last;
  logic [DATA_W-1:0]       w_addend;
  logic [DATA_W-1:0]       w_prod_next;

  // Operand forwarding: 01 takes writeback, 10 takes the EX/MEM result.
  always_comb begin
    case (ex.ForwardAE)
      2'b01:   w_srca = ex.ResultW;
      2'b10:   w_srca = ex.ALUResultM;
      default: w_srca = ex.RD1E;
    endcase
    case (ex.ForwardBE)
      2'b01:   w_fwdb = ex.ResultW;
      2'b10:   w_fwdb = ex.ALUResultM;
      default: w_fwdb = ex.RD2E;
    endcase
    w_srcb = ex.ALUSrcE ? ex.ImmExtE : w_fwdb;
  end

  // Single-cycle ALU; MUL goes through the iterative path instead.
  always_comb begin
    w_alu = '0;
    case (ex.ALUControlE)
      OP_ADD:  w_alu = w_srca + w_srcb;
      OP_SUB:  w_alu = w_srca - w_srcb;
      OP_AND:  w_alu = w_srca & w_srcb;
      OP_OR:   w_alu = w_srca | w_srcb;
      OP_XOR:  w_alu = w_srca ^ w_srcb;
      OP_SLL:  w_alu = f_shl(w_srca, w_srcb[4:0]);
      OP_SRL:  w_alu = f_shr(w_srca, w_srcb[4:0]);
      default: w_alu = '0;
    endcase
  end

  assign w_a_s = w_srca;
  assign w_b_s = w_fwdb;

  // Branch conditions compare the two forwarded register operands.
  always_comb begin
    case (ex.BranchE)
      2'b01:   w_cond = (w_srca == w_fwdb);
      2'b10:   w_cond = (w_srca != w_fwdb);
      2'b11:   w_cond = (w_a_s < w_b_s);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_is_mul    = (ex.ALUControlE == OP_MUL);
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign w_prod_next = r_prod + w_addend;

  assign ex.PCTargetE = ex.PCE + ex.ImmExtE[PC_W-1:0];
  assign ex.PCSrcE    = ~reset & (r_state == S_IDLE) & (ex.JumpE | w_cond);
  assign ex.BusyE     = ~reset & (((r_state == S_IDLE) & w_is_mul) |
                                  ((r_state == S_MUL) & (r_cnt != CNT_LAST)));

  // Multiplier FSM: latch operands and controls on entry, one shift-add per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_rw     <= 1'b0;
      r_mw     <= 1'b0;
      r_rs     <= 1'b0;
      r_cb     <= 1'b0;
      r_rd     <= '0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_state  <= S_MUL;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= w_srca;
            r_mplier <= w_srcb;
            r_rw     <= ex.RegWriteE;
            r_mw     <= ex.MemWriteE;
            r_rs     <= ex.ResultSrcE;
            r_cb     <= ex.Cant_ByteE;
            r_rd     <= ex.RDE;
            r_wd     <= w_fwdb;
          end
        end
        default: begin
          if (w_mul_last) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
      endcase
    end
  end

  // EX/MEM register: ALU result, final product, or a zeroed bubble while MUL runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex.RegWriteM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.ResultSrcM <= 1'b0;
      ex.Cant_ByteM <= 1'b0;
      ex.ALUResultM <= '0;
      ex.WriteDataM <= '0;
      ex.RdM        <= '0;
    end else if (w_mul_last) begin
      ex.RegWriteM  <= r_rw;
      ex.MemWriteM  <= r_mw;
      ex.ResultSrcM <= r_rs;
      ex.Cant_ByteM <= r_cb;
      ex.ALUResultM <= w_prod_next;
      ex.WriteDataM <= r_wd;
      ex.RdM        <= r_rd;
    end else if ((r_state == S_MUL) || w_is_mul) begin
      ex.RegWriteM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.ResultSrcM <= 1'b0;
      ex.Cant_ByteM <= 1'b0;
      ex.ALUResultM <= '0;
      ex.WriteDataM <= '0;
      ex.RdM        <= '0;
    end else begin
      ex.RegWriteM  <= ex.RegWriteE;
      ex.MemWriteM  <= ex.MemWriteE;
      ex.ResultSrcM <= ex.ResultSrcE;
      ex.Cant_ByteM <= ex.Cant_ByteE;
      ex.ALUResultM <= w_alu;
      ex.WriteDataM <= w_fwdb;
      ex.RdM        <= ex.RDE;
    end
  end
endmodule
